// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encodings, denomination values
// and dispenser state encodings, reused by the core and the change dispenser.
package vm_pkg;

  // Default field widths of the change breakdown produced by the core.
  localparam int W10_DEF  = 2;
  localparam int W5_DEF   = 1;
  localparam int W1_DEF   = 3;
  localparam int WSUM_DEF = 6;

  // Denomination values.
  localparam int VAL10_DEF = 10;
  localparam int VAL5_DEF  = 5;
  localparam int VAL1_DEF  = 1;

  // Width of the coin-value output bus.
  localparam int WVAL = 5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_UNIT = 2'd1,
    COIN_FIVE = 2'd2,
    COIN_TEN  = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    DSP_IDLE = 2'd0,
    DSP_DISP = 2'd1,
    DSP_DONE = 2'd2
  } disp_state_t;

endpackage : vm_pkg

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers the previous level and pulses for one
// cycle when the level goes from 0 to 1. Reusable for switch inputs.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_level;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A reset value of 1 masks a level that is already high at reset release.
  assign o_rise = i_level & ~prev_q;

endmodule : rise_detect

// File: rtl/change_dispenser.sv
// Change dispenser: latches the 10/5/1 coin breakdown on a start edge and
// pays it out largest-coin-first, one coin per tick, with hold support.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int W10   = W10_DEF,
  parameter int W5    = W5_DEF,
  parameter int W1    = W1_DEF,
  parameter int VAL10 = VAL10_DEF,
  parameter int VAL5  = VAL5_DEF,
  parameter int VAL1  = VAL1_DEF,
  parameter int WSUM  = WSUM_DEF
) (
  input  logic            clk_1,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_hold,
  input  logic [W10-1:0]  i_num_10,
  input  logic [W5-1:0]   i_num_5,
  input  logic [W1-1:0]   i_num_1,
  output logic            o_busy,
  output logic            o_coin_valid,
  output logic [1:0]      o_coin_type,
  output logic [WVAL-1:0] o_coin_value,
  output logic [W10-1:0]  o_rem_10,
  output logic [W5-1:0]   o_rem_5,
  output logic [W1-1:0]   o_rem_1,
  output logic [WSUM-1:0] o_paid,
  output logic            o_done
);

  logic start_rise;

  disp_state_t     state_q,      state_d;
  logic [W10-1:0]  rem_10_q,     rem_10_d;
  logic [W5-1:0]   rem_5_q,      rem_5_d;
  logic [W1-1:0]   rem_1_q,      rem_1_d;
  logic [WSUM-1:0] paid_q,       paid_d;
  logic            coin_valid_q, coin_valid_d;
  coin_t           coin_type_q,  coin_type_d;
  logic [WVAL-1:0] coin_value_q, coin_value_d;
  logic            done_q,       done_d;

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_start_rise (
    .clk     (clk_1),
    .reset   (reset),
    .i_level (i_start),
    .o_rise  (start_rise)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rem_10_d     = rem_10_q;
    rem_5_d      = rem_5_q;
    rem_1_d      = rem_1_q;
    paid_d       = paid_q;
    coin_valid_d = 1'b0;
    coin_type_d  = COIN_NONE;
    coin_value_d = '0;
    done_d       = 1'b0;

    unique case (state_q)
      DSP_IDLE: begin
        if (start_rise) begin
          rem_10_d = i_num_10;
          rem_5_d  = i_num_5;
          rem_1_d  = i_num_1;
          paid_d   = '0;
          if ((i_num_10 == '0) && (i_num_5 == '0) && (i_num_1 == '0)) begin
            state_d = DSP_DONE;
          end else begin
            state_d = DSP_DISP;
          end
        end
      end

      DSP_DISP: begin
        if (!i_hold) begin
          // Only a nonzero count is ever decremented, so none can underflow.
          if (rem_10_q != '0) begin
            rem_10_d     = rem_10_q - W10'(1);
            paid_d       = paid_q + WSUM'(VAL10);
            coin_valid_d = 1'b1;
            coin_type_d  = COIN_TEN;
            coin_value_d = WVAL'(VAL10);
          end else if (rem_5_q != '0) begin
            rem_5_d      = rem_5_q - W5'(1);
            paid_d       = paid_q + WSUM'(VAL5);
            coin_valid_d = 1'b1;
            coin_type_d  = COIN_FIVE;
            coin_value_d = WVAL'(VAL5);
          end else if (rem_1_q != '0) begin
            rem_1_d      = rem_1_q - W1'(1);
            paid_d       = paid_q + WSUM'(VAL1);
            coin_valid_d = 1'b1;
            coin_type_d  = COIN_UNIT;
            coin_value_d = WVAL'(VAL1);
          end
          // The edge that pays the last coin also leaves DISP.
          if ((rem_10_d == '0) && (rem_5_d == '0) && (rem_1_d == '0)) begin
            state_d = DSP_DONE;
          end
        end
      end

      DSP_DONE: begin
        done_d  = 1'b1;
        state_d = DSP_IDLE;
      end

      default: begin
        state_d = DSP_IDLE;
      end
    endcase
  end

  // NOTE: reset is asynchronous and active-high; it aborts a payout at once
  // and discards whatever coins were still owed.
  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      state_q      <= DSP_IDLE;
      rem_10_q     <= '0;
      rem_5_q      <= '0;
      rem_1_q      <= '0;
      paid_q       <= '0;
      coin_valid_q <= 1'b0;
      coin_type_q  <= COIN_NONE;
      coin_value_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_10_q     <= rem_10_d;
      rem_5_q      <= rem_5_d;
      rem_1_q      <= rem_1_d;
      paid_q       <= paid_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      coin_value_q <= coin_value_d;
      done_q       <= done_d;
    end
  end

  // Busy comes straight from the state register, so it is glitch-free.
  assign o_busy       = (state_q != DSP_IDLE);
  assign o_coin_valid = coin_valid_q;
  assign o_coin_type  = coin_type_q;
  assign o_coin_value = coin_value_q;
  assign o_rem_10     = rem_10_q;
  assign o_rem_5      = rem_5_q;
  assign o_rem_1      = rem_1_q;
  assign o_paid       = paid_q;
  assign o_done       = done_q;

endmodule : change_dispenser

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// traffic, each compared against a queue-based payout model.
module tb_change_dispenser;

  logic       clk_1 = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_hold;
  logic [1:0] i_num_10;
  logic [0:0] i_num_5;
  logic [2:0] i_num_1;
  logic       o_busy;
  logic       o_coin_valid;
  logic [1:0] o_coin_type;
  logic [4:0] o_coin_value;
  logic [1:0] o_rem_10;
  logic [0:0] o_rem_5;
  logic [2:0] o_rem_1;
  logic [5:0] o_paid;
  logic       o_done;

  int checks = 0;
  int errors = 0;

  change_dispenser dut (
    .clk_1        (clk_1),
    .reset        (reset),
    .i_start      (i_start),
    .i_hold       (i_hold),
    .i_num_10     (i_num_10),
    .i_num_5      (i_num_5),
    .i_num_1      (i_num_1),
    .o_busy       (o_busy),
    .o_coin_valid (o_coin_valid),
    .o_coin_type  (o_coin_type),
    .o_coin_value (o_coin_value),
    .o_rem_10     (o_rem_10),
    .o_rem_5      (o_rem_5),
    .o_rem_1      (o_rem_1),
    .o_paid       (o_paid),
    .o_done       (o_done)
  );

  always #5 clk_1 = ~clk_1;

  // Reference model: the coins still owed as a queue of values, paid from the front.
  int          owed[$];
  bit          m_busy;
  bit          m_done_pending;
  bit          m_prev;
  int          m_paid;
  bit          m_valid;
  int          m_value;
  bit          m_done;
  logic [21:0] exp_vec;

  function automatic int type_of(input int v);
    if (v == 10) return 3;
    if (v == 5)  return 2;
    if (v == 1)  return 1;
    return 0;
  endfunction

  function automatic logic [21:0] obs_vec();
    return {o_busy, o_coin_valid, o_coin_type, o_coin_value,
            o_rem_10, o_rem_5, o_rem_1, o_paid, o_done};
  endfunction

  task automatic build_exp();
    int c10 = 0;
    int c5  = 0;
    int c1  = 0;
    foreach (owed[i]) begin
      if (owed[i] == 10) c10++;
      else if (owed[i] == 5) c5++;
      else c1++;
    end
    exp_vec = {m_busy, m_valid, 2'(type_of(m_value)), 5'(m_value),
               2'(c10), 1'(c5), 3'(c1), 6'(m_paid), m_done};
  endtask

  task automatic model_reset();
    owed.delete();
    m_busy         = 1'b0;
    m_done_pending = 1'b0;
    m_prev         = 1'b1;
    m_paid         = 0;
    m_valid        = 1'b0;
    m_value        = 0;
    m_done         = 1'b0;
    build_exp();
  endtask

  // Applies one clock tick of the payout rules to the model.
  task automatic model_edge();
    bit rise = i_start && !m_prev;
    m_prev  = i_start;
    m_valid = 1'b0;
    m_value = 0;
    m_done  = 1'b0;
    if (!m_busy) begin
      if (rise) begin
        owed.delete();
        for (int i = 0; i < int'(i_num_10); i++) owed.push_back(10);
        for (int i = 0; i < int'(i_num_5);  i++) owed.push_back(5);
        for (int i = 0; i < int'(i_num_1);  i++) owed.push_back(1);
        m_paid         = 0;
        m_busy         = 1'b1;
        m_done_pending = (owed.size() == 0);
      end
    end else if (m_done_pending) begin
      m_done         = 1'b1;
      m_busy         = 1'b0;
      m_done_pending = 1'b0;
    end else if (!i_hold) begin
      m_value        = owed.pop_front();
      m_valid        = 1'b1;
      m_paid         = m_paid + m_value;
      m_done_pending = (owed.size() == 0);
    end
    build_exp();
  endtask

  task automatic step(input logic start, input logic hold,
                      input logic [1:0] n10, input logic n5, input logic [2:0] n1);
    i_start  = start;
    i_hold   = hold;
    i_num_10 = n10;
    i_num_5  = n5;
    i_num_1  = n1;
    @(posedge clk_1);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 2'd3, 1'b1, 3'd7);
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 22'h0);
    end
    reset = 1'b0;
    // Start held high across release, then low: nothing may launch.
    for (int i = 0; i < 4; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b0, 2'd3, 1'b1, 3'd7);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    int got[$];
    int want[6] = '{10, 10, 5, 1, 1, 1};
    int done_at = -1;
    step(1'b1, 1'b0, 2'd2, 1'b1, 3'd3);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
      if (o_coin_valid) got.push_back(int'(o_coin_value));
      if (o_done && done_at < 0) done_at = i;
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] != want[i]) begin
          errors++;
          $display("FAIL basic_order idx=%0d got=%0d exp=%0d", i, got[i], want[i]);
        end
      end
    end
    checks++;
    if (done_at != 7) begin
      errors++;
      $display("FAIL basic_done_edge got=%0d exp=7", done_at);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic test_zero();
    step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL zero cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
      step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    end
  endtask

  task automatic test_hold();
    bit holds[7] = '{0, 0, 1, 1, 0, 0, 0};
    step(1'b1, 1'b0, 2'd1, 1'b0, 3'd2);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, holds[i], 2'd0, 1'b0, 3'd0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL hold cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (o_paid !== 6'd12) begin
      errors++;
      $display("FAIL hold_paid got=%0d exp=12", o_paid);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic test_back_to_back();
    bit lvl[4] = '{0, 1, 1, 0};
    step(1'b1, 1'b0, 2'd0, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      step(lvl[i], 1'b0, 2'd3, 1'b1, 3'd7);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (o_paid !== 6'd6) begin
      errors++;
      $display("FAIL restart_paid got=%0d exp=6", o_paid);
    end
    step(1'b1, 1'b0, 2'd1, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL relaunch cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (o_paid !== 6'd10) begin
      errors++;
      $display("FAIL relaunch_paid got=%0d exp=10", o_paid);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 2'd2, 1'b0, 3'd0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 22'h0);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd2, 1'b0, 3'd0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_max();
    int strobes = 0;
    step(1'b1, 1'b0, 2'd2, 1'b1, 3'd7);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL max cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
      if (o_coin_valid) strobes++;
    end
    checks++;
    if (strobes != 10 || o_paid !== 6'd32 || !o_done ||
        {o_rem_10, o_rem_5, o_rem_1} !== 6'd0) begin
      errors++;
      $display("FAIL max_final got=strobes %0d paid %0d done %0b rem %0d/%0d/%0d exp=strobes 10 paid 32 done 1 rem 0/0/0",
               strobes, o_paid, o_done, o_rem_10, o_rem_5, o_rem_1);
    end
    step(1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic test_random();
    logic start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      step(start, ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_change_dispenser
